primo_varredura: RTL and testbench

Sequential range scanner that sits directly upstream of the combinational 16-bit prime detector `primo`. It drives `primo`'s N input with consecutive values from a programmed start to a programmed end, one per clock, and samples F in the same cycle. It forwards every prime found on a valid/ready output stream and keeps a running prime count. The scan stalls cleanly under downstream backpressure.

---
 rtl/primo_varredura.sv | 93 +++++++++
 tb/tb_primo_varredura.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/primo_varredura.sv
// Range scanner feeding the 16-bit prime detector: walks n_out from ini to fim,
// forwards each prime on a valid/ready stream and counts primes found.
module primo_varredura #(
    parameter int unsigned LARGURA      = 16,
    parameter int unsigned LARGURA_CONT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    go,
    input  logic [LARGURA-1:0]      ini,
    input  logic [LARGURA-1:0]      fim,
    output logic [LARGURA-1:0]      n_out,
    input  logic                    f_in,
    output logic [LARGURA-1:0]      prim_data,
    output logic                    prim_valid,
    input  logic                    prim_ready,
    output logic [LARGURA_CONT-1:0] contagem,
    output logic                    ocupado,
    output logic                    done
);

    typedef enum logic [1:0] {OCIOSO, VARRE, FIM} estado_t;

    estado_t                 estado, estado_nx;
    logic [LARGURA-1:0]      lim, lim_nx, n_nx, dado_nx;
    logic                    valido_nx;
    logic [LARGURA_CONT-1:0] cont_nx;
    logic                    aceita;

    always_comb begin
        estado_nx = estado;
        lim_nx    = lim;
        n_nx      = n_out;
        dado_nx   = prim_data;
        valido_nx = prim_valid;
        cont_nx   = contagem;
        aceita    = !f_in || !prim_valid || prim_ready;

        case (estado)
            OCIOSO, FIM: begin
                if (estado == FIM)
                    valido_nx = prim_valid && !prim_ready;
                // prim_valid is always 0 in OCIOSO, so this also gates FIM on done=1
                if (go && !prim_valid) begin
                    lim_nx    = fim;
                    n_nx      = ini;
                    cont_nx   = '0;
                    estado_nx = (ini <= fim) ? VARRE : FIM;
                end
            end
            VARRE: begin
                if (aceita) begin
                    if (f_in) begin
                        dado_nx   = n_out;
                        valido_nx = 1'b1;
                        cont_nx   = contagem + 1'b1;
                    end else begin
                        valido_nx = prim_valid && !prim_ready;
                    end
                    // equality test before increment avoids wrap when lim is all ones
                    if (n_out == lim)
                        estado_nx = FIM;
                    else
                        n_nx = n_out + 1'b1;
                end
            end
            default: estado_nx = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            lim        <= '0;
            n_out      <= '0;
            prim_data  <= '0;
            prim_valid <= 1'b0;
            contagem   <= '0;
            ocupado    <= 1'b0;
            done       <= 1'b0;
        end else begin
            estado     <= estado_nx;
            lim        <= lim_nx;
            n_out      <= n_nx;
            prim_data  <= dado_nx;
            prim_valid <= valido_nx;
            contagem   <= cont_nx;
            ocupado    <= (estado_nx == VARRE);
            done       <= (estado_nx == FIM) && !valido_nx;
        end
    end

endmodule

// File: tb/tb_primo_varredura.sv
// Directed bench for primo_varredura; the prime detector is modelled by a
// trial-division function driving f_in from n_out.
module tb_primo_varredura;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [15:0] ini = '0;
    logic [15:0] fim = '0;
    logic [15:0] n_out;
    logic        f_in;
    logic [15:0] prim_data;
    logic        prim_valid;
    logic        prim_ready = 1'b1;
    logic [15:0] contagem;
    logic        ocupado;
    logic        done;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    function automatic logic is_prime(input logic [15:0] n);
        int nn;
        nn = int'(n);
        if (nn < 2) return 1'b0;
        for (int d = 2; d * d <= nn; d++)
            if (nn % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    assign f_in = is_prime(n_out);

    primo_varredura #(.LARGURA(16), .LARGURA_CONT(16)) dut (
        .clock(clock), .reset(reset), .go(go), .ini(ini), .fim(fim),
        .n_out(n_out), .f_in(f_in), .prim_data(prim_data),
        .prim_valid(prim_valid), .prim_ready(prim_ready),
        .contagem(contagem), .ocupado(ocupado), .done(done)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] ini;
        logic [15:0] fim;
        int          cnt;
        logic [15:0] first;
        logic [15:0] last;
        int          dur;
        int          stall_on;
        int          rst_at;
        bit          inject;
    } vec_t;

    vec_t vt[9];

    task automatic run(input vec_t v, input int idx);
        logic [15:0] got[$];
        int  dur = 0;
        int  stall_left = 0;
        bit  stall_used = 0;
        bit  finished = 0;
        bit  ordered = 1;
        string tag;
        tag = $sformatf("v%0d", idx);

        @(negedge clock);
        ini = v.ini; fim = v.fim; go = 1'b1; prim_ready = 1'b1;
        @(negedge clock);
        go = 1'b0;

        for (int g = 0; g < 2000; g++) begin
            if (done) begin
                finished = 1;
                break;
            end
            if (ocupado) dur++;

            if (v.rst_at >= 0 && int'(n_out) == v.rst_at) begin
                #2 reset = 1'b1;
                #1 check({tag, "_rst_outputs"},
                         {n_out, prim_data, prim_valid, contagem, ocupado, done}, 0);
                #1 reset = 1'b0;
                return;
            end

            go = 1'b0;
            if (v.inject && dur == 3) begin
                go = 1'b1; ini = 16'd50; fim = 16'd60;
            end

            if (v.stall_on != 0 && !stall_used && prim_valid && int'(prim_data) == v.stall_on) begin
                stall_left = 5;
                stall_used = 1;
            end
            if (stall_left > 0) begin
                prim_ready = 1'b0;
                if (stall_left == 1) check({tag, "_stall_n_out"}, n_out, 5);
                stall_left--;
            end else begin
                prim_ready = 1'b1;
            end

            if (prim_valid && prim_ready) begin
                if (got.size() > 0 && prim_data <= got[got.size()-1]) ordered = 0;
                if (!is_prime(prim_data) || prim_data < v.ini || prim_data > v.fim) ordered = 0;
                got.push_back(prim_data);
            end
            @(negedge clock);
        end
        go = 1'b0;
        prim_ready = 1'b1;

        check({tag, "_finished"}, finished, 1);
        check({tag, "_emitted"}, got.size(), v.cnt);
        check({tag, "_contagem"}, contagem, v.cnt);
        check({tag, "_dur"}, dur, v.dur);
        check({tag, "_order"}, ordered, 1);
        check({tag, "_n_final"}, n_out, (v.ini > v.fim) ? v.ini : v.fim);
        if (v.cnt > 0 && got.size() > 0) begin
            check({tag, "_first"}, got[0], v.first);
            check({tag, "_last"}, got[got.size()-1], v.last);
        end
    endtask

    initial begin
        //        ini    fim    cnt first  last   dur stall rst inject
        vt[0] = '{16'd0,     16'd15,    6, 16'd2,     16'd13,    16, 0, -1, 0};
        vt[1] = '{16'd0,     16'd15,    6, 16'd2,     16'd13,    20, 3, -1, 0};
        vt[2] = '{16'd65520, 16'd65535, 1, 16'd65521, 16'd65521, 16, 0, -1, 0};
        vt[3] = '{16'd20,    16'd10,    0, 16'd0,     16'd0,      0, 0, -1, 0};
        vt[4] = '{16'd0,     16'd100,   0, 16'd0,     16'd0,      0, 0, 40, 0};
        vt[5] = '{16'd0,     16'd10,    4, 16'd2,     16'd7,     11, 0, -1, 0};
        vt[6] = '{16'd0,     16'd15,    6, 16'd2,     16'd13,    16, 0, -1, 1};
        vt[7] = '{16'd90,    16'd100,   1, 16'd97,    16'd97,    11, 0, -1, 0};
        vt[8] = '{16'd7,     16'd7,     1, 16'd7,     16'd7,      1, 0, -1, 0};

        #1;
        check("reset_outputs", {n_out, prim_data, prim_valid, contagem, ocupado, done}, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ocupado", ocupado, 0);
        check("idle_done", done, 0);

        for (int i = 0; i < 9; i++) run(vt[i], i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
